// File: rtl/regression_mac.sv
// Sequential multiply-accumulate for linear regression: y = c0 + cin + sum(coef[i]*feat[i]),
// one product per cycle, saturating at the accumulator width, with valid/ready handshakes.
module regression_mac #(
  parameter int N_FEAT = 3,
  parameter int DW     = 16,
  parameter int ACC_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACC_W-1:0]     c0,
  input  logic [N_FEAT*DW-1:0] coef,
  input  logic [N_FEAT*DW-1:0] feat,
  input  logic                 cin,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_W-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int SUM_W = ACC_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (ACC_W < 2 * DW) begin : g_bad_acc_w
    $error("regression_mac: ACC_W must be at least 2*DW");
  end
  if ((N_FEAT < 1) || (N_FEAT > 16)) begin : g_bad_n_feat
    $error("regression_mac: N_FEAT must lie in 1..16");
  end

  logic [1:0]        state_r;
  logic [ACC_W-1:0]  acc_r;
  logic [IDX_W-1:0]  idx_r;
  logic              sat_int_r;
  logic [DW-1:0]     coef_q [N_FEAT];
  logic [DW-1:0]     feat_q [N_FEAT];
  logic [ACC_W-1:0]  y_r;
  logic              sat_r;
  logic              out_valid_r;

  logic [DW-1:0]     coef_sel_s;
  logic [DW-1:0]     feat_sel_s;
  logic [2*DW-1:0]   prod_s;
  logic [SUM_W-1:0]  mac_sum_s;
  logic [SUM_W-1:0]  init_sum_s;
  logic              last_s;

  // Any carry out of the ACC_W-bit sum pins the value at all-ones.
  function automatic logic [ACC_W-1:0] clamp(input logic [SUM_W-1:0] s);
    if (s[ACC_W]) begin
      clamp = {ACC_W{1'b1}};
    end else begin
      clamp = s[ACC_W-1:0];
    end
  endfunction

  // Operand select for the current MAC step, built as an AND-OR mux over all pairs.
  always_comb begin
    coef_sel_s = {DW{1'b0}};
    feat_sel_s = {DW{1'b0}};
    for (int i = 0; i < N_FEAT; i++) begin
      coef_sel_s = coef_sel_s | ({DW{idx_r == IDX_W'(i)}} & coef_q[i]);
      feat_sel_s = feat_sel_s | ({DW{idx_r == IDX_W'(i)}} & feat_q[i]);
    end
  end

  assign prod_s     = {{DW{1'b0}}, coef_sel_s} * {{DW{1'b0}}, feat_sel_s};
  assign mac_sum_s  = {1'b0, acc_r} + {{(SUM_W-2*DW){1'b0}}, prod_s};
  assign init_sum_s = {1'b0, c0} + {{ACC_W{1'b0}}, cin};
  assign last_s     = (idx_r == IDX_W'(N_FEAT - 1));

  // in_ready is gated by rst_n so it reads low for the whole reset assertion.
  assign in_ready  = rst_n && (state_r == IDLE);
  assign y         = y_r;
  assign sat       = sat_r;
  assign out_valid = out_valid_r;

  // Control FSM, accumulator and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      sat_int_r   <= 1'b0;
      y_r         <= {ACC_W{1'b0}};
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) begin
        coef_q[i] <= {DW{1'b0}};
        feat_q[i] <= {DW{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_FEAT; i++) begin
              coef_q[i] <= coef[i*DW +: DW];
              feat_q[i] <= feat[i*DW +: DW];
            end
            acc_r     <= clamp(init_sum_s);
            sat_int_r <= init_sum_s[ACC_W];
            idx_r     <= {IDX_W{1'b0}};
            state_r   <= MAC;
          end
        end
        MAC: begin
          acc_r     <= clamp(mac_sum_s);
          sat_int_r <= sat_int_r | mac_sum_s[ACC_W];
          idx_r     <= idx_r + IDX_W'(1);
          if (last_s) begin
            state_r     <= DONE;
            y_r         <= clamp(mac_sum_s);
            sat_r       <= sat_int_r | mac_sum_s[ACC_W];
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            y_r         <= {ACC_W{1'b0}};
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          y_r         <= {ACC_W{1'b0}};
          sat_r       <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regression_mac.sv
// Bench for regression_mac: four configurations (default plus N_FEAT 1/4/8 at DW=8, ACC_W=16)
// compared every cycle against a transaction-level reference, plus directed literal checks.
module tb_regression_mac;

  localparam int NCFG = 4;
  localparam int N_TAB  [NCFG] = '{3, 1, 4, 8};
  localparam int DW_TAB [NCFG] = '{16, 8, 8, 8};
  localparam int AW_TAB [NCFG] = '{32, 16, 16, 16};

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  localparam logic [63:0] COEF_A = {16'd0, 16'd65, 16'd700, 16'd200};
  localparam logic [63:0] FEAT_A = {16'd0, 16'd600, 16'd30000, 16'd1000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCFG-1:0][31:0] c0_v;
  logic [NCFG-1:0][63:0] coef_v;
  logic [NCFG-1:0][63:0] feat_v;
  logic [NCFG-1:0]       cin_v;
  logic [NCFG-1:0]       in_valid_v;
  logic [NCFG-1:0]       out_ready_v;
  wire  [NCFG-1:0]       in_ready_v;
  wire  [NCFG-1:0]       out_valid_v;
  wire  [NCFG-1:0]       sat_v;
  wire  [NCFG-1:0][31:0] y_v;

  int n_tests = 0;
  int n_fail  = 0;

  int              m_state [NCFG] = '{0, 0, 0, 0};
  int              m_cnt   [NCFG] = '{0, 0, 0, 0};
  longint unsigned m_y     [NCFG] = '{0, 0, 0, 0};
  logic            m_sat   [NCFG] = '{1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  for (genvar k = 0; k < NCFG; k++) begin : g_dut
    localparam int NK = N_TAB[k];
    localparam int DK = DW_TAB[k];
    localparam int AK = AW_TAB[k];
    regression_mac #(.N_FEAT(NK), .DW(DK), .ACC_W(AK)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .c0        (c0_v[k][AK-1:0]),
      .coef      (coef_v[k][NK*DK-1:0]),
      .feat      (feat_v[k][NK*DK-1:0]),
      .cin       (cin_v[k]),
      .in_valid  (in_valid_v[k]),
      .in_ready  (in_ready_v[k]),
      .y         (y_v[k][AK-1:0]),
      .out_valid (out_valid_v[k]),
      .out_ready (out_ready_v[k]),
      .sat       (sat_v[k])
    );
    if (AK < 32) begin : g_pad
      assign y_v[k][31:AK] = '0;
    end
  end

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint unsigned lim_of(input int k);
    return (64'd1 << AW_TAB[k]) - 64'd1;
  endfunction

  // Exact, unbounded sum of the operand set currently on the inputs of configuration k.
  function automatic longint unsigned raw_sum(input int k);
    longint unsigned s;
    longint unsigned dm;
    dm = (64'd1 << DW_TAB[k]) - 64'd1;
    s = (64'(c0_v[k]) & lim_of(k)) + 64'(cin_v[k]);
    for (int i = 0; i < N_TAB[k]; i++) begin
      s += ((coef_v[k] >> (i * DW_TAB[k])) & dm) * ((feat_v[k] >> (i * DW_TAB[k])) & dm);
    end
    return s;
  endfunction

  function automatic logic [63:0] op_mask(input int k);
    if (N_TAB[k] * DW_TAB[k] >= 64) return {64{1'b1}};
    return (64'd1 << (N_TAB[k] * DW_TAB[k])) - 64'd1;
  endfunction

  // Reference: result fixed at accept, visible N_FEAT edges later until handshake.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NCFG; k++) begin
      if (!rst_n) begin
        m_state[k] <= M_IDLE;
        m_cnt[k]   <= 0;
      end else if (m_state[k] == M_IDLE) begin
        if (in_valid_v[k]) begin
          m_y[k]     <= (raw_sum(k) > lim_of(k)) ? lim_of(k) : raw_sum(k);
          m_sat[k]   <= (raw_sum(k) > lim_of(k));
          m_cnt[k]   <= 0;
          m_state[k] <= M_BUSY;
        end
      end else if (m_state[k] == M_BUSY) begin
        m_cnt[k] <= m_cnt[k] + 1;
        if (m_cnt[k] + 1 == N_TAB[k]) m_state[k] <= M_DONE;
      end else begin
        if (out_ready_v[k]) m_state[k] <= M_IDLE;
      end
    end
  end

  // Every-cycle comparison of all outputs of all configurations.
  always @(negedge clk) begin
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("cfg%0d in_ready", k), 64'(in_ready_v[k]),
          64'(rst_n && (m_state[k] == M_IDLE)));
      chk($sformatf("cfg%0d out_valid", k), 64'(out_valid_v[k]), 64'(m_state[k] == M_DONE));
      chk($sformatf("cfg%0d y", k), 64'(y_v[k]), (m_state[k] == M_DONE) ? m_y[k] : 64'd0);
      chk($sformatf("cfg%0d sat", k), 64'(sat_v[k]),
          64'((m_state[k] == M_DONE) && m_sat[k]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the default configuration with literal expectations.
  task automatic txn(input logic [31:0] a, input logic [63:0] cf, input logic [63:0] fe,
                     input logic ci, input int hold, input longint unsigned ey, input logic es);
    int lat;
    c0_v[0] = a; coef_v[0] = cf; feat_v[0] = fe; cin_v[0] = ci;
    out_ready_v[0] = (hold == 0);
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    c0_v[0] = $urandom; coef_v[0] = {16'd0, 16'($urandom), 16'($urandom), 16'($urandom)};
    feat_v[0] = {16'd0, 16'($urandom), 16'($urandom), 16'($urandom)}; cin_v[0] = ~ci;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid_v[0] && lat < 20);
    chk("latency", 64'(lat), 64'd3);
    chk("result y", 64'(y_v[0]), ey);
    chk("result sat", 64'(sat_v[0]), 64'(es));
    for (int h = 0; h < hold; h++) begin
      in_valid_v[0] = 1'b1;
      step();
      chk("held y", 64'(y_v[0]), ey);
      chk("held out_valid", 64'(out_valid_v[0]), 64'd1);
      chk("held in_ready", 64'(in_ready_v[0]), 64'd0);
    end
    out_ready_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    chk("post handshake out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("post handshake in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("post handshake y", 64'(y_v[0]), 64'd0);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("reset y", 64'(y_v[0]), 64'd0);
    chk("reset sat", 64'(sat_v[0]), 64'd0);
    chk("reset in_ready", 64'(in_ready_v[0]), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  initial begin
    int cnt;
    c0_v = '0; coef_v = '0; feat_v = '0; cin_v = '0;
    in_valid_v = '0; out_ready_v = '1;
    step();
    step();
    chk("in_ready during reset", 64'(in_ready_v[0]), 64'd0);
    #2 rst_n = 1'b1;
    step();
    chk("idle in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("idle y", 64'(y_v[0]), 64'd0);
    chk("idle out_valid", 64'(out_valid_v[0]), 64'd0);

    txn(32'd50000, COEF_A, FEAT_A, 1'b0, 0, 64'd21289000, 1'b0);
    txn(32'd50000, COEF_A, FEAT_A, 1'b1, 10, 64'd21289001, 1'b0);
    txn(32'hFFFF_FFF6, 64'd4, 64'd4, 1'b0, 0, 64'd4294967295, 1'b1);
    txn(32'd0, 64'd0, 64'd0, 1'b0, 0, 64'd0, 1'b0);

    // in_valid held high with operands changing every cycle
    in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b1;
    cnt = 0;
    repeat (25) begin
      c0_v[0] = $urandom; cin_v[0] = 1'($urandom);
      coef_v[0] = {16'd0, 16'($urandom), 16'($urandom), 16'($urandom)};
      feat_v[0] = {16'd0, 16'($urandom), 16'($urandom), 16'($urandom)};
      step();
      if (out_valid_v[0]) cnt++;
    end
    chk("issue spacing results", 64'(cnt), 64'd5);
    in_valid_v[0] = 1'b0;
    repeat (8) step();

    // reset during MAC at idx 1
    c0_v[0] = 32'd50000; coef_v[0] = COEF_A; feat_v[0] = FEAT_A; cin_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    step();
    pulse_reset();
    cnt = 0;
    repeat (5) begin
      step();
      if (out_valid_v[0]) cnt++;
    end
    chk("no out_valid after abort", 64'(cnt), 64'd0);
    txn(32'd50000, COEF_A, FEAT_A, 1'b0, 0, 64'd21289000, 1'b0);

    // reset while a result is waiting under backpressure
    out_ready_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    repeat (3) step();
    chk("done before reset", 64'(out_valid_v[0]), 64'd1);
    pulse_reset();
    out_ready_v[0] = 1'b1;
    txn(32'd7, 64'd3, 64'd5, 1'b1, 0, 64'd23, 1'b0);

    // randomized traffic on all configurations
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NCFG; k++) begin
        in_valid_v[k]  = ($urandom_range(0, 3) != 0);
        out_ready_v[k] = ($urandom_range(0, 2) != 0);
        c0_v[k]   = 32'(64'($urandom) & lim_of(k));
        cin_v[k]  = 1'($urandom);
        coef_v[k] = {$urandom, $urandom} & op_mask(k);
        feat_v[k] = {$urandom, $urandom} & op_mask(k);
        if ($urandom_range(0, 1) == 0) feat_v[k] = feat_v[k] & 64'h0303_0303_0303_0303;
      end
      step();
    end
    in_valid_v = '0;
    out_ready_v = '1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
